// File: rtl/morse_pkg.sv
// Shared types, result codes and the Morse sequence-to-code decode function
// for the Morse key decoder.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_WORD_WAIT
  } state_t;

  localparam logic [5:0] CODE_SPACE   = 6'd36;
  localparam logic [5:0] CODE_INVALID = 6'd63;

  // The longest International Morse letter or digit has five elements.
  localparam int LUT_SYMS = 5;

  // bits[0] is the first element received; 1 = dash. Only the first n bits
  // are meaningful. The sequence is re-packed first-element-in-MSB so the
  // table below reads left to right like written Morse.
  function automatic logic [5:0] morse_decode(input logic [3:0] n,
                                              input logic [LUT_SYMS-1:0] bits);
    logic [LUT_SYMS-1:0] seq;
    logic [5:0]          code;
    seq  = '0;
    code = CODE_INVALID;
    for (int i = 0; i < LUT_SYMS; i++) begin
      if (i < int'(n)) seq = {seq[LUT_SYMS-2:0], bits[i]};
    end
    case (n)
      4'd1: begin
        case (seq[0])
          1'b0:    code = 6'd4;   // E
          default: code = 6'd19;  // T
        endcase
      end
      4'd2: begin
        case (seq[1:0])
          2'b01:   code = 6'd0;   // A
          2'b00:   code = 6'd8;   // I
          2'b10:   code = 6'd13;  // N
          default: code = 6'd12;  // M
        endcase
      end
      4'd3: begin
        case (seq[2:0])
          3'b000:  code = 6'd18;  // S
          3'b001:  code = 6'd20;  // U
          3'b010:  code = 6'd17;  // R
          3'b011:  code = 6'd22;  // W
          3'b100:  code = 6'd3;   // D
          3'b101:  code = 6'd10;  // K
          3'b110:  code = 6'd6;   // G
          default: code = 6'd14;  // O
        endcase
      end
      4'd4: begin
        case (seq[3:0])
          4'b0000: code = 6'd7;   // H
          4'b0001: code = 6'd21;  // V
          4'b0010: code = 6'd5;   // F
          4'b0100: code = 6'd11;  // L
          4'b0110: code = 6'd15;  // P
          4'b0111: code = 6'd9;   // J
          4'b1000: code = 6'd1;   // B
          4'b1001: code = 6'd23;  // X
          4'b1010: code = 6'd2;   // C
          4'b1011: code = 6'd24;  // Y
          4'b1100: code = 6'd25;  // Z
          4'b1101: code = 6'd16;  // Q
          default: code = CODE_INVALID;
        endcase
      end
      4'd5: begin
        case (seq[4:0])
          5'b11111: code = 6'd26; // 0
          5'b01111: code = 6'd27; // 1
          5'b00111: code = 6'd28; // 2
          5'b00011: code = 6'd29; // 3
          5'b00001: code = 6'd30; // 4
          5'b00000: code = 6'd31; // 5
          5'b10000: code = 6'd32; // 6
          5'b11000: code = 6'd33; // 7
          5'b11100: code = 6'd34; // 8
          5'b11110: code = 6'd35; // 9
          default:  code = CODE_INVALID;
        endcase
      end
      default: code = CODE_INVALID;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse lookup: element count plus element bits to result code.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMS  = 5,
  parameter int SYM_CNT_W = $clog2(MAX_SYMS + 1)
) (
  input  logic [SYM_CNT_W-1:0] sym_cnt,
  input  logic [MAX_SYMS-1:0]  sym_bits,
  output logic [5:0]           code
);

  logic [LUT_SYMS-1:0] bits_fit;

  // Fit the element store to the table width; counts above LUT_SYMS decode
  // as invalid anyway, so trimming extra bits loses nothing.
  generate
    if (MAX_SYMS >= LUT_SYMS) begin : g_trim
      assign bits_fit = sym_bits[LUT_SYMS-1:0];
    end else begin : g_pad
      assign bits_fit = {{(LUT_SYMS-MAX_SYMS){1'b0}}, sym_bits};
    end
  endgenerate

  // Pure table lookup
  always_comb begin
    code = morse_decode(4'(sym_cnt), bits_fit);
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times key marks and gaps, assembles dot/dash elements,
// and emits letter/digit codes and word spaces through a valid/ready port.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int GLITCH_TICKS = 2,
  parameter int DASH_TICKS   = 20,
  parameter int LETTER_GAP   = 30,
  parameter int WORD_GAP     = 70,
  parameter int MAX_SYMS     = 5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       key,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [5:0] out_code,
  output logic       overflow,
  output logic       busy
);

  localparam int SYM_CNT_W = $clog2(MAX_SYMS + 1);

  localparam logic [CNT_W-1:0]     GLITCH_LEN  = CNT_W'(GLITCH_TICKS);
  localparam logic [CNT_W-1:0]     DASH_LEN    = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0]     LETTER_LEN  = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0]     WORD_LEN    = CNT_W'(WORD_GAP);
  localparam logic [SYM_CNT_W-1:0] SYM_FULL    = SYM_CNT_W'(MAX_SYMS);

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     mark_cnt;
  logic [CNT_W-1:0]     gap_cnt;
  logic [CNT_W-1:0]     mark_inc;
  logic [CNT_W-1:0]     gap_inc;
  logic [SYM_CNT_W-1:0] sym_cnt;
  logic [MAX_SYMS-1:0]  sym_bits;
  logic                 sym_inv;
  logic                 word_has_char;
  logic                 elem_ok;
  logic                 elem_dash;
  logic                 letter_end;
  logic                 word_end;
  logic                 new_res;
  logic [5:0]           lut_code;
  logic [5:0]           res_code;
  logic                 accept;

  // Saturating increments and the event strobes derived from the counters
  always_comb begin
    mark_inc   = (mark_cnt == '1) ? mark_cnt : mark_cnt + 1'b1;
    gap_inc    = (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;
    elem_ok    = (state == ST_MARK) && !key && (mark_cnt >= GLITCH_LEN);
    elem_dash  = (mark_cnt >= DASH_LEN);
    letter_end = (state == ST_GAP) && !key && (gap_inc == LETTER_LEN);
    word_end   = (state == ST_WORD_WAIT) && !key && (gap_inc == WORD_LEN);
    new_res    = (letter_end && (sym_cnt != '0)) || (word_end && word_has_char);
    res_code   = word_end ? CODE_SPACE : (sym_inv ? CODE_INVALID : lut_code);
    accept     = out_valid && out_ready;
    busy       = (state == ST_MARK) || (state == ST_GAP);
  end

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (key) state_nx = ST_MARK;
      ST_MARK:      if (!key) state_nx = ST_GAP;
      ST_GAP: begin
        if (key)             state_nx = ST_MARK;
        else if (letter_end) state_nx = ST_WORD_WAIT;
      end
      ST_WORD_WAIT: begin
        if (key)           state_nx = ST_MARK;
        else if (word_end) state_nx = ST_IDLE;
      end
      default:      state_nx = ST_IDLE;
    endcase
  end

  // Mark and gap duration counters; each restarts at 1 on its first sample
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mark_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_MARK: begin
          if (key) mark_cnt <= mark_inc;
          else     gap_cnt  <= CNT_W'(1);
        end
        ST_GAP, ST_WORD_WAIT: begin
          if (key) mark_cnt <= CNT_W'(1);
          else     gap_cnt  <= gap_inc;
        end
        default: begin
          if (key) mark_cnt <= CNT_W'(1);
        end
      endcase
    end
  end

  // Element store: append on each valid mark, clear when the letter closes
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sym_cnt  <= '0;
      sym_bits <= '0;
      sym_inv  <= 1'b0;
    end else if (letter_end) begin
      sym_cnt  <= '0;
      sym_bits <= '0;
      sym_inv  <= 1'b0;
    end else if (elem_ok) begin
      if (sym_cnt == SYM_FULL) begin
        sym_inv <= 1'b1;
      end else begin
        sym_bits[sym_cnt] <= elem_dash;
        sym_cnt           <= sym_cnt + 1'b1;
      end
    end
  end

  // Remembers whether the current word has produced a character yet
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                                  word_has_char <= 1'b0;
    else if (word_end)                          word_has_char <= 1'b0;
    else if (letter_end && (sym_cnt != '0))     word_has_char <= 1'b1;
  end

  // Single-entry output holding register with sticky drop flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      overflow  <= 1'b0;
    end else if (new_res) begin
      if (!out_valid || accept) begin
        out_valid <= 1'b1;
        out_code  <= res_code;
      end else begin
        overflow <= 1'b1;
      end
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  morse_lut #(
    .MAX_SYMS  (MAX_SYMS),
    .SYM_CNT_W (SYM_CNT_W)
  ) u_lut (
    .sym_cnt  (sym_cnt),
    .sym_bits (sym_bits),
    .code     (lut_code)
  );

endmodule

// File: doc/morse_key_decoder.md
MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the mark and gap duration counters, in bits.
REQ-002 SHALL have parameter GLITCH_TICKS, default 2: marks shorter than this many cycles are ignored.
REQ-003 SHALL have parameter DASH_TICKS, default 20: marks at least this long are dashes; shorter valid marks are dots.
REQ-004 SHALL have parameter LETTER_GAP, default 30: low cycles that end a character.
REQ-005 SHALL have parameter WORD_GAP, default 70 (> LETTER_GAP): low cycles that end a word.
REQ-006 SHALL have parameter MAX_SYMS, default 5: maximum elements per character.
REQ-007 SHALL have port Clock  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port key  input  1  debounced, Clock-synchronous key level (1 = key down).
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_code this cycle.
REQ-011 SHALL have port out_valid  output  1  out_code holds an unaccepted result.
REQ-012 SHALL have port out_code  output  6  result code: 0-25 = A-Z, 26-35 = digits 0-9, 36 = word space, 63 = invalid.
REQ-013 SHALL have port overflow  output  1  sticky flag: a result was dropped.
REQ-014 SHALL have port busy  output  1  high while a character is being assembled (MARK or GAP state).

Function
REQ-015 SHALL implement FSM states IDLE, MARK, GAP and WORD_WAIT.
  - IDLE -> MARK on key=1.
  - MARK -> GAP on key=0.
  - GAP -> MARK on key=1 before LETTER_GAP is reached.
  - GAP -> WORD_WAIT when LETTER_GAP is reached.
  - WORD_WAIT -> MARK on key=1.
  - WORD_WAIT -> IDLE when WORD_GAP is reached.
REQ-016 SHALL count mark cycles in MARK and gap cycles in GAP/WORD_WAIT; both counters saturate at 2^CNT_W-1 and never wrap.
REQ-017 SHALL classify each mark on the key falling edge:
  - length < GLITCH_TICKS: discarded, element count unchanged;
  - length < DASH_TICKS: dot;
  - otherwise: dash.
REQ-018 SHALL store elements in order, with a 1 meaning dash, and hold the element count (0..MAX_SYMS).
REQ-019 SHALL set an internal invalid flag when an element arrives while the count equals MAX_SYMS; later elements of that character are ignored.
REQ-020 SHALL emit one result when the gap count reaches LETTER_GAP and the element count is > 0:
  - the result is produced exactly LETTER_GAP cycles after the first low sample;
  - its code is the table code, or 63 if the invalid flag is set or the sequence is not in the table;
  - element count and invalid flag then clear.
REQ-021 SHALL emit code 36 exactly once when the gap count reaches WORD_GAP after at least one character in the word, and SHALL emit nothing further while key stays low.
REQ-022 SHALL raise and hold out_valid with out_code stable until out_valid and out_ready are both high in the same cycle.
REQ-023 SHALL handle a new result arriving in the same cycle as a handshake by loading it, with out_valid remaining 1.
REQ-024 SHALL drop a new result that arrives while a held result is not accepted, keep the held data unchanged, and set overflow until reset.
REQ-025 SHALL decode the full A-Z and 0-9 International Morse table; every other sequence of 1 to MAX_SYMS elements maps to 63.

Reset
REQ-026 SHALL, while Reset=1 (asynchronous), force:
  - state = IDLE;
  - both counters, the element count, the element bits and the invalid flag = 0;
  - out_valid = 0, out_code = 0, overflow = 0, busy = 0.
REQ-027 SHALL discard any partially assembled character when reset is asserted mid-operation; after release, the first key=1 starts a fresh character.

Structure
REQ-028 SHALL place the FSM state enum, the code constants (CODE_SPACE = 36, CODE_INVALID = 63) and the sequence-to-code decode function in package morse_pkg.
REQ-029 SHALL implement the sequence-to-code lookup as combinational sub-module morse_lut, instantiated once, with inputs element count and element bits and output code.

Verification
REQ-030 Bench SHALL cover idle and glitch: default params, key low 200 cycles, then a 1-cycle key pulse -> out_valid never asserts, busy=0 after the pulse.
REQ-031 Bench SHALL cover decode of A: key 10 high, 10 low, 25 high, then low, out_ready=1 -> out_valid high for exactly one cycle, 30 cycles after the last falling edge, out_code=0.
REQ-032 Bench SHALL cover the length limit:
  - five 25-cycle marks separated by 10-cycle gaps -> code 26;
  - six 10-cycle dots -> code 63.
REQ-033 Bench SHALL cover word space: key 10 high, then low 200 cycles -> code 4 at gap 30, code 36 at gap 70, no further results.
REQ-034 Bench SHALL cover backpressure: out_ready=0, send E then T -> out_code stays 4 with out_valid=1, overflow=1 after T completes; raising out_ready accepts 4 and out_valid falls.
REQ-035 Bench SHALL cover reset mid-mark: Reset pulsed 15 cycles into a mark -> outputs 0 within the same cycle; a following 10-cycle mark plus 30 low cycles yields code 4.
